// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: moves a WIDTH-bit operand one bit position per clock
// and reports the final value and the last bit shifted or rotated out.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or DONE);
  // busy stays high for exactly the shift cycles, and done is a one-cycle pulse
  // during which dout/carry already hold the new result. start while busy is dropped.

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [AMT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             cbit_q;
  logic [WIDTH-1:0] dout_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] sreg_d;
  logic             out_bit;
  logic             accept;
  logic             real_shift;

  always_comb begin
    sreg_d  = sreg_q;
    out_bit = 1'b0;
    unique case (op_q)
      OP_LSL: begin
        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
        out_bit = sreg_q[WIDTH-1];
      end
      OP_LSR: begin
        sreg_d  = {1'b0, sreg_q[WIDTH-1:1]};
        out_bit = sreg_q[0];
      end
      OP_ASR: begin
        sreg_d  = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
        out_bit = sreg_q[0];
      end
      OP_ROL: begin
        sreg_d  = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
        out_bit = sreg_q[WIDTH-1];
      end
      OP_ROR: begin
        sreg_d  = {sreg_q[0], sreg_q[WIDTH-1:1]};
        out_bit = sreg_q[0];
      end
      default: begin
        sreg_d  = sreg_q;
        out_bit = 1'b0;
      end
    endcase
  end

  assign accept     = start && (state_q != S_SHIFT);
  // Pass, reserved opcodes and a zero count complete straight from the accept edge.
  assign real_shift = (amt != '0) && (op >= OP_LSL) && (op <= OP_ROR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      cbit_q  <= 1'b0;
      dout_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          sreg_q <= sreg_d;
          cbit_q <= out_bit;
          cnt_q  <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q <= S_DONE;
            dout_q  <= sreg_d;
            carry_q <= out_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            sreg_q <= din;
            cnt_q  <= amt;
            op_q   <= op;
            cbit_q <= 1'b0;
            if (real_shift) begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= S_DONE;
              dout_q  <= din;
              carry_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dout      = dout_q;
  assign carry     = carry_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed cases plus random requests checked against a
// transaction-level model that computes each result with plain shift arithmetic.
module tb_seq_shifter;

  localparam int W = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [2:0]    op;
  logic [3:0]    amt;
  logic [W-1:0]  din;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
  logic          carry;
  logic [1:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0]    exp_q[$];      // {carry, dout} of each accepted request
  logic [W-1:0]  model_dout;
  logic          model_carry;

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .amt       (amt),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .carry     (carry),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result of shifting d by a positions in one step.
  function automatic void model(input logic [2:0] o, input logic [3:0] a, input logic [W-1:0] d,
                                output int n, output logic [W-1:0] r, output logic c);
    int ai;
    ai = int'(a);
    if (a == 4'd0 || o == 3'd0 || o > 3'd5) begin
      n = 0;
      r = d;
      c = 1'b0;
    end else begin
      n = ai;
      case (o)
        3'd1:    begin r = d << ai;                       c = d[W - ai]; end
        3'd2:    begin r = d >> ai;                       c = d[ai - 1]; end
        3'd3:    begin r = W'($signed(d) >>> ai);         c = d[ai - 1]; end
        3'd4:    begin r = (d << ai) | (d >> (W - ai));   c = d[W - ai]; end
        default: begin r = (d >> ai) | (d << (W - ai));   c = d[ai - 1]; end
      endcase
    end
  endfunction

  // Called 1 time unit after a rising edge with busy=0. Returns 1 time unit after
  // the edge that raises done, so a caller may chain another request back-to-back.
  task automatic run_op(input logic [2:0] o, input logic [3:0] a, input logic [W-1:0] d,
                        input bit poke);
    int           n;
    logic [W-1:0] r;
    logic         c;
    logic [W:0]   e;
    model(o, a, d, n, r, c);
    exp_q.push_back({c, r});
    start = 1'b1; op = o; amt = a; din = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check_eq("busy_during_shift", {31'd0, busy}, 32'd1);
      check_eq("no_done_during_shift", {31'd0, done}, 32'd0);
      check_eq("dout_hold", {16'd0, dout}, {16'd0, model_dout});
      if (poke && k == 0) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); amt = 4'($urandom); din = ~d;
      end else begin
        start = 1'b0; din = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_low_at_done", {31'd0, busy}, 32'd0);
    check_eq("dout", {16'd0, dout}, {16'd0, e[W-1:0]});
    check_eq("carry", {31'd0, carry}, {31'd0, e[W]});
    model_dout  = e[W-1:0];
    model_carry = e[W];
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_dout_hold", {16'd0, dout}, {16'd0, model_dout});
    check_eq("idle_carry_hold", {31'd0, carry}, {31'd0, model_carry});
  endtask

  initial begin
    logic [2:0]   dir_op  [6];
    logic [3:0]   dir_amt [6];
    logic [W-1:0] dir_din [6];
    dir_op  = '{3'b001, 3'b011, 3'b101, 3'b100, 3'b010, 3'b111};
    dir_amt = '{4'd1,   4'd4,   4'd4,   4'd15,  4'd0,   4'd5};
    dir_din = '{16'hF0F0, 16'h8001, 16'h1234, 16'h1234, 16'hA5A5, 16'hA5A5};

    reset_n = 1'b0; start = 1'b0; op = '0; amt = '0; din = '0;
    model_dout = '0; model_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_dout", {16'd0, dout}, 32'd0);
    check_eq("reset_carry", {31'd0, carry}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, each followed by an idle cycle
    for (int i = 0; i < 6; i++) begin
      run_op(dir_op[i], dir_amt[i], dir_din[i], 1'b0);
      idle_cycle();
    end

    // start while busy must be ignored
    run_op(3'b001, 4'd5, 16'h1357, 1'b1);
    idle_cycle();
    run_op(3'b101, 4'd1, 16'h0001, 1'b1);
    idle_cycle();

    // Back-to-back: new request raised in the DONE cycle
    run_op(3'b100, 4'd3, 16'h8421, 1'b0);
    run_op(3'b011, 4'd2, 16'hC003, 1'b0);
    run_op(3'b000, 4'd7, 16'h5A5A, 1'b0);
    idle_cycle();

    // Asynchronous reset two cycles into an 8-step shift
    start = 1'b1; op = 3'b001; amt = 4'd8; din = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    model_dout = '0; model_carry = 1'b0;
    check_eq("midop_reset_busy", {31'd0, busy}, 32'd0);
    check_eq("midop_reset_done", {31'd0, done}, 32'd0);
    check_eq("midop_reset_dout", {16'd0, dout}, 32'd0);
    check_eq("midop_reset_carry", {31'd0, carry}, 32'd0);
    check_eq("midop_reset_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      check_eq("no_done_after_abort", {31'd0, done}, 32'd0);
      check_eq("no_busy_after_abort", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    run_op(3'b010, 4'd3, 16'h8001, 1'b0);
    idle_cycle();

    // Random requests, random chaining and busy pokes
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom),
             bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
